fir_dac_ctrl: RTL and testbench

Parametrised output stage for the FIR demo: selects one of `NUM_CH` filtered sample streams, using a debounced push-button that cycles the selection. It streams the selected sample continuously to a TLC5615-style serial DAC. It replaces the fixed 3-way key mux and fixed 10-bit serializer pair with one block, generalised in channel count, sample width, pad bits and serial clock rate. It sits between the FIR bank outputs and the DAC pins.

---
 rtl/fir_dac_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fir_dac_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_dac_ctrl.sv
// Channel-select + TLC5615-style serial DAC driver; key press cycles the channel (optional debounce: FIR_DAC_KEY_DEBOUNCE_EN).
// Latency: first cs fall 2*DIV clk after reset release; frame = (1 + 2*(DATA_W+PAD_W) + CS_IDLE) ticks.
// Backpressure: none; the DAC is streamed continuously and ch_data is sampled only at LOAD.
`timescale 1ns/1ps
module fir_dac_ctrl #(
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 2,
    parameter int DATA_W     = 10,
    parameter int PAD_W      = 2,
    parameter int DIV        = 8,
    parameter int CS_IDLE    = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     key_in,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     sclk,
    output logic                     din,
    output logic                     cs,
    output logic [CH_W-1:0]          ch_sel,
    output logic                     frame_done
);

    localparam int FRM_W = DATA_W + PAD_W;
    localparam int TCW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCMAX = (FRM_W > CS_IDLE) ? FRM_W : CS_IDLE;
    localparam int BCW   = $clog2(BCMAX + 1);

    if (NUM_CH < 2 || NUM_CH > (1 << CH_W) || DIV < 1 || CS_IDLE < 1 ||
        DEB_CYCLES < 1 || FRM_W < 2) begin : g_bad_param
        $error("fir_dac_ctrl: illegal parameter combination");
    end

    // Tick generator
    logic [TCW-1:0] tcnt_q;
    logic           tick;

    assign tick = (tcnt_q == TCW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  tcnt_q <= '0;
        else if (tick) tcnt_q <= '0;
        else           tcnt_q <= tcnt_q + 1'b1;
    end

    // Key synchronizer, idle (released) level is 1
    logic [1:0] sync_q;
    logic       key_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], key_in};
    end

    assign key_s = sync_q[1];

    logic deb_lvl;

`ifdef FIR_DAC_KEY_DEBOUNCE_EN
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    logic [DCW-1:0] deb_cnt_q;
    logic           deb_q;

    // Count consecutive samples that differ from the accepted level; any return restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b1;
        end else if (key_s == deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DCW'(DEB_CYCLES - 1)) begin
            deb_q     <= key_s;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    assign deb_lvl = deb_q;
`else
    assign deb_lvl = key_s;
`endif

    logic deb_prev_q;
    logic press;

    assign press = deb_prev_q & ~deb_lvl;

    logic [CH_W-1:0] ch_sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q <= 1'b1;
            ch_sel_q   <= '0;
        end else begin
            deb_prev_q <= deb_lvl;
            if (press)
                ch_sel_q <= (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
        end
    end

    logic [DATA_W-1:0] sample_d;
    logic [FRM_W-1:0]  frame_d;

    always_comb begin
        sample_d = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_sel_q == CH_W'(i))
                sample_d = ch_data[i*DATA_W +: DATA_W];
    end

    assign frame_d = FRM_W'(sample_d) << PAD_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t           state_q;
    logic [FRM_W-2:0] sr_q;      // bits still to go after the one on din
    logic [BCW-1:0]   bcnt_q;
    logic             rise_q;
    logic             sclk_q;
    logic             din_q;
    logic             cs_q;
    logic             fd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            rise_q  <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            cs_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    S_IDLE: state_q <= S_LOAD;
                    S_LOAD: begin
                        sr_q    <= frame_d[FRM_W-2:0];
                        din_q   <= frame_d[FRM_W-1];
                        cs_q    <= 1'b0;
                        bcnt_q  <= BCW'(FRM_W);
                        rise_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (rise_q) begin
                            sclk_q <= 1'b1;
                            rise_q <= 1'b0;
                        end else begin
                            sclk_q <= 1'b0;
                            rise_q <= 1'b1;
                            if (bcnt_q > BCW'(1)) begin
                                bcnt_q <= bcnt_q - 1'b1;
                                din_q  <= sr_q[FRM_W-2];
                                sr_q   <= sr_q << 1;
                            end else begin
                                cs_q    <= 1'b1;
                                din_q   <= 1'b0;
                                fd_q    <= 1'b1;
                                bcnt_q  <= BCW'(CS_IDLE);
                                state_q <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (bcnt_q <= BCW'(1)) state_q <= S_LOAD;
                        else                   bcnt_q  <= bcnt_q - 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sclk       = sclk_q;
    assign din        = din_q;
    assign cs         = cs_q;
    assign ch_sel     = ch_sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_fir_dac_ctrl.sv
// Directed bench for fir_dac_ctrl: table of channel/press vectors plus reset, bounce and mid-frame sequences.
`timescale 1ns/1ps
module tb_fir_dac_ctrl;

    localparam int NUM_CH  = 3;
    localparam int CH_W    = 2;
    localparam int DATA_W  = 10;
    localparam int PAD_W   = 2;
    localparam int DIV     = 2;
    localparam int CS_IDLE = 4;
    localparam int DEB     = 16;
    localparam int FRM_W   = DATA_W + PAD_W;
    localparam int FRM_CLK = (1 + 2*FRM_W + CS_IDLE) * DIV;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     key_in = 1'b1;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic                     sclk, din, cs, frame_done;
    logic [CH_W-1:0]          ch_sel;

    always #5 clk = ~clk;

    fir_dac_ctrl #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .PAD_W(PAD_W),
        .DIV(DIV), .CS_IDLE(CS_IDLE), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_in(key_in), .ch_data(ch_data),
        .sclk(sclk), .din(din), .cs(cs), .ch_sel(ch_sel), .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Frame capture: bits taken on sclk rise while cs is low; only full frames count.
    logic [FRM_W-1:0] cap = '0;
    logic [FRM_W-1:0] last_word = '0;
    int               nbits = 0;
    int               frames = 0;
    int               fd_cnt = 0;

    always @(negedge cs) begin
        nbits = 0;
        cap   = '0;
    end

    always @(posedge sclk) if (cs === 1'b0) begin
        cap   = {cap[FRM_W-2:0], din};
        nbits = nbits + 1;
    end

    always @(posedge cs) begin
        if (nbits == FRM_W) begin
            last_word = cap;
            frames    = frames + 1;
        end
        nbits = 0;
    end

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;

    task automatic set_ch(input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2);
        ch_data = {d2, d1, d0};
    endtask

    task automatic press();
        @(negedge clk);
        key_in = 1'b0;
        repeat (40) @(negedge clk);
        key_in = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_frames(input int n);
        int start;
        start = frames;
        for (int i = 0; i < n*FRM_CLK + 200; i++) begin
            @(negedge clk);
            if (frames >= start + n) return;
        end
        timeout("frame_wait");
    endtask

    task automatic wait_cs_fall();
        logic prev;
        prev = cs;
        for (int i = 0; i < 4*FRM_CLK; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && cs === 1'b0) return;
            prev = cs;
        end
        timeout("cs_fall_wait");
    endtask

    typedef struct {
        logic [9:0]       d0, d1, d2;
        int               presses;
        logic [CH_W-1:0]  exp_sel;
        logic [FRM_W-1:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int per;
        logic seen_hi;
        logic [CH_W-1:0] exp_b;

        vecs[0] = '{10'h2AB, 10'h155, 10'h3FF, 0, 2'd0, 12'hAAC};
        vecs[1] = '{10'h2AB, 10'h155, 10'h3FF, 1, 2'd1, 12'h554};
        vecs[2] = '{10'h2AB, 10'h155, 10'h3FF, 1, 2'd2, 12'hFFC};
        vecs[3] = '{10'h001, 10'h155, 10'h3FF, 1, 2'd0, 12'h004};
        vecs[4] = '{10'h001, 10'h155, 10'h200, 2, 2'd2, 12'h800};
        vecs[5] = '{10'h001, 10'h155, 10'h0F0, 0, 2'd2, 12'h3C0};

        set_ch(10'h2AB, 10'h155, 10'h3FF);
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_din", din, 0);
        check("rst_cs", cs, 1);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_frame_done", frame_done, 0);

        reset_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (cs === 1'b0) begin
                lat = i;
                break;
            end
        end
        check("cs_fall_latency", lat, 2*DIV);

        per = 0;
        seen_hi = 1'b0;
        fd_cnt = 0;
        for (int k = 1; k <= 3*FRM_CLK; k++) begin
            @(posedge clk);
            #1;
            if (cs === 1'b1) seen_hi = 1'b1;
            else if (seen_hi) begin
                per = k;
                break;
            end
        end
        check("frame_period", per, FRM_CLK);
        check("frame_done_pulses", fd_cnt, 1);

        for (int v = 0; v < 6; v++) begin
            set_ch(vecs[v].d0, vecs[v].d1, vecs[v].d2);
            for (int p = 0; p < vecs[v].presses; p++) press();
            wait_frames(2);
            check($sformatf("vec%0d_ch_sel", v), ch_sel, vecs[v].exp_sel);
            check($sformatf("vec%0d_word", v), last_word, vecs[v].exp_word);
        end

        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            key_in = 1'b0;
            repeat (5) @(negedge clk);
            key_in = 1'b1;
            repeat (12) @(negedge clk);
        end
        repeat (30) @(negedge clk);
`ifdef FIR_DAC_KEY_DEBOUNCE_EN
        exp_b = vecs[5].exp_sel;
`else
        exp_b = CH_W'((int'(vecs[5].exp_sel) + 2) % NUM_CH);
`endif
        check("bounce_ch_sel", ch_sel, exp_b);

        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        set_ch(10'h2AB, 10'h155, 10'h3FF);
        wait_cs_fall();
        key_in = 1'b0;
        wait_frames(1);
        check("midshift_old_word", last_word, 12'hAAC);
        check("midshift_ch_sel", ch_sel, 1);
        key_in = 1'b1;
        wait_frames(1);
        check("midshift_next_word", last_word, 12'h554);

        set_ch(10'h0C3, 10'h155, 10'h3FF);
        wait_cs_fall();
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_sclk", sclk, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs", cs, 1);
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_ch_sel", ch_sel, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_frames(1);
        check("after_rst_word", last_word, 12'h30C);
        check("after_rst_ch_sel", ch_sel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
